// File: rtl/yadmc_memtest_pkg.sv
// Shared definitions for the SDRAM memory tester: CSR offsets, STAT bits,
// FSM encoding and the pattern LFSR.
package yadmc_memtest_pkg;

  localparam logic [2:0] CSR_CTRL     = 3'd0;
  localparam logic [2:0] CSR_BASE     = 3'd1;
  localparam logic [2:0] CSR_COUNT    = 3'd2;
  localparam logic [2:0] CSR_SEED     = 3'd3;
  localparam logic [2:0] CSR_STAT     = 3'd4;
  localparam logic [2:0] CSR_ERRCNT   = 3'd5;
  localparam logic [2:0] CSR_FIRSTERR = 3'd6;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_ABORTED = 4;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/yadmc_memtest_if.sv
// Wishbone initiator bus between the memory tester and the SDRAM controller slave port.
interface yadmc_memtest_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/yadmc_lfsr32.sv
// 32-bit Galois LFSR used as the test pattern generator; load wins over step.
module yadmc_lfsr32
  import yadmc_memtest_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)   value <= 32'd1;
    else if (load) value <= seed;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/yadmc_memtest.sv
// Wishbone memory tester: writes an LFSR pattern over [BASE, BASE+4*COUNT),
// reads it back and counts mismatches; controlled through a CSR page.
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | issuing pattern writes, one access at a time
// READ    | reading back and comparing against the regenerated pattern
// DONE    | one cycle: set done, clear busy
module yadmc_memtest
  import yadmc_memtest_pkg::*;
#(
  parameter logic [3:0]  csr_addr       = 4'h1,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  yadmc_memtest_if.master wb,
  output logic        busy
);

  localparam int TW = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(timeout_cycles - 1);

  state_t        state_q, state_d;
  logic [31:0]   base_q, count_q, seed_q, errcnt_q, firsterr_q, index_q;
  logic [TW-1:0] wait_q;
  logic          done_q, error_q, timeout_q, aborted_q, busy_q, abort_q;
  logic          cyc_q, we_q;
  logic [31:0]   adr_q, dat_q;
  logic [31:0]   lfsr_val;

  logic csr_sel, csr_wr, start_req;
  logic ack_ok, last, mismatch;
  logic start_go, issue, acc_done, tmo, abort_now, lfsr_load, lfsr_step;
  logic unused_ok;

  assign csr_sel   = (csr_a[13:10] == csr_addr);
  assign csr_wr    = csr_sel & csr_we;
  assign start_req = csr_wr & (csr_a[2:0] == CSR_CTRL) & csr_di[0];
  assign ack_ok    = cyc_q & wb.wbm_ack_i;
  assign last      = (index_q == count_q - 32'd1);
  assign mismatch  = (wb.wbm_dat_i != lfsr_val);
  assign unused_ok = &{1'b0, csr_a[9:3], index_q[31:30]};

  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = cyc_q;
  assign wb.wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;
  assign wb.wbm_we_o  = we_q;
  assign busy         = busy_q;

  yadmc_lfsr32 u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .seed    (seed_q),
    .value   (lfsr_val)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_go  = 1'b0;
    issue     = 1'b0;
    acc_done  = 1'b0;
    tmo       = 1'b0;
    abort_now = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          start_go  = 1'b1;
          lfsr_load = 1'b1;
          state_d   = (count_q == 32'd0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE, S_READ: begin
        // cyc low here is the access boundary, the only place abort is honoured
        if (!cyc_q) begin
          if (abort_q) begin
            abort_now = 1'b1;
            state_d   = S_DONE;
          end else begin
            issue = 1'b1;
          end
        end else if (ack_ok) begin
          acc_done = 1'b1;
          if (!last) begin
            lfsr_step = 1'b1;
          end else if (state_q == S_WRITE) begin
            lfsr_load = 1'b1;
            state_d   = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end else if (wait_q == '0) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      base_q     <= 32'd0;
      count_q    <= 32'd0;
      seed_q     <= 32'd1;
      errcnt_q   <= 32'd0;
      firsterr_q <= 32'd0;
      index_q    <= 32'd0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      aborted_q  <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      csr_do     <= 32'd0;
    end else begin
      if (csr_wr && !busy_q) begin
        case (csr_a[2:0])
          CSR_BASE:  base_q  <= {csr_di[31:2], 2'b00};
          CSR_COUNT: count_q <= csr_di;
          CSR_SEED:  seed_q  <= (csr_di == 32'd0) ? 32'd1 : csr_di;
          default: ;
        endcase
      end
      if (csr_wr && busy_q && (csr_a[2:0] == CSR_CTRL) && csr_di[1])
        abort_q <= 1'b1;

      if (start_go) begin
        errcnt_q   <= 32'd0;
        firsterr_q <= 32'd0;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
        timeout_q  <= 1'b0;
        aborted_q  <= 1'b0;
        index_q    <= 32'd0;
        busy_q     <= 1'b1;
        abort_q    <= 1'b0;
      end

      if (issue) begin
        cyc_q  <= 1'b1;
        we_q   <= (state_q == S_WRITE);
        adr_q  <= base_q + {index_q[29:0], 2'b00};
        dat_q  <= lfsr_val;
        wait_q <= WAIT_LOAD;
      end else if (cyc_q && !ack_ok && !tmo) begin
        wait_q <= wait_q - TW'(1);
      end

      if (acc_done || tmo) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
      end

      if (acc_done) begin
        index_q <= last ? 32'd0 : index_q + 32'd1;
        if (state_q == S_READ && mismatch) begin
          error_q <= 1'b1;
          if (errcnt_q != 32'hFFFF_FFFF) errcnt_q <= errcnt_q + 32'd1;
          if (errcnt_q == 32'd0) firsterr_q <= adr_q;
        end
      end

      if (tmo)       timeout_q <= 1'b1;
      if (abort_now) aborted_q <= 1'b1;

      if (state_q == S_DONE) begin
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        abort_q <= 1'b0;
      end

      csr_do <= 32'd0;
      if (csr_sel) begin
        case (csr_a[2:0])
          CSR_BASE:     csr_do <= base_q;
          CSR_COUNT:    csr_do <= count_q;
          CSR_SEED:     csr_do <= seed_q;
          CSR_STAT:     csr_do <= {27'd0, aborted_q, timeout_q, error_q, done_q, busy_q};
          CSR_ERRCNT:   csr_do <= errcnt_q;
          CSR_FIRSTERR: csr_do <= firsterr_q;
          default:      csr_do <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yadmc_memtest.sv
// Directed bench for yadmc_memtest: Wishbone slave model with configurable
// latency/corruption and an access scoreboard.
module tb_yadmc_memtest;

  localparam logic [3:0] PAGE = 4'h1;
  localparam logic [2:0] A_CTRL = 3'd0, A_BASE = 3'd1, A_COUNT = 3'd2, A_SEED = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4, A_ERRCNT = 3'd5, A_FIRSTERR = 3'd6;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        busy;

  yadmc_memtest_if wb();

  yadmc_memtest #(.csr_addr(PAGE), .timeout_cycles(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .wb      (wb),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  int          lat = 0;
  bit          rand_lat = 1'b0;
  bit          never_ack = 1'b0;
  logic [63:0] corrupt = '0;
  logic [31:0] sl_base = '0;
  logic [31:0] sl_idx;
  int          wl = 0;
  bit          in_acc = 1'b0;
  int          rises = 0;
  int          run = 0;
  int          last_run = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] mem [logic [31:0]];
  acc_t        sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic push_run(input logic [31:0] base, input int n, input logic [31:0] seed, input bit reads);
    logic [31:0] l;
    l = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < n; i++) begin
      sb.push_back(acc_t'{we: 1'b1, adr: base + 32'(i * 4), dat: l});
      l = lstep(l);
    end
    if (reads) begin
      l = (seed == 32'd0) ? 32'd1 : seed;
      for (int i = 0; i < n; i++) begin
        sb.push_back(acc_t'{we: 1'b0, adr: base + 32'(i * 4), dat: l});
        l = lstep(l);
      end
    end
  endtask

  // Slave model and bus monitor, evaluated 1 time unit after each edge.
  always @(posedge sys_clk) begin
    acc_t e;
    #1;
    if (wb.wbm_cyc_o && !prev_cyc) rises++;
    if (wb.wbm_cyc_o) run++;
    else begin
      if (prev_cyc) last_run = run;
      run = 0;
    end
    prev_cyc = wb.wbm_cyc_o;

    if (sys_rst) begin
      wb.wbm_ack_i = 1'b0;
      wb.wbm_dat_i = 32'd0;
      in_acc = 1'b0;
    end else if (wb.wbm_ack_i) begin
      wb.wbm_ack_i = 1'b0;
      in_acc = 1'b0;
      chk("gap_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        wl = rand_lat ? int'($urandom_range(0, 7)) : lat;
        chk("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_we", {31'd0, wb.wbm_we_o}, {31'd0, e.we});
          chk("sb_adr", wb.wbm_adr_o, e.adr);
          if (e.we) chk("sb_dat", wb.wbm_dat_o, e.dat);
          chk("sb_sel", {28'd0, wb.wbm_sel_o}, 32'hF);
        end
      end
      if (!never_ack) begin
        if (wl == 0) begin
          wb.wbm_ack_i = 1'b1;
          if (wb.wbm_we_o) mem[wb.wbm_adr_o] = wb.wbm_dat_o;
          else begin
            sl_idx = (wb.wbm_adr_o - sl_base) >> 2;
            wb.wbm_dat_i = (mem.exists(wb.wbm_adr_o) ? mem[wb.wbm_adr_o] : 32'd0)
                           ^ {31'd0, corrupt[sl_idx[5:0]]};
          end
        end else begin
          wl--;
        end
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  task automatic csr_wr(input logic [2:0] off, input logic [31:0] v);
    @(negedge sys_clk);
    csr_a  = {PAGE, 7'd0, off};
    csr_di = v;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] off, output logic [31:0] d);
    csr_a  = {PAGE, 7'd0, off};
    csr_we = 1'b0;
    @(posedge sys_clk);
    #1 d = csr_do;
  endtask

  task automatic wait_done(output logic [31:0] stat);
    stat = '0;
    for (int n = 0; n < 3000; n++) begin
      csr_rd(A_STAT, stat);
      if (stat[1]) break;
    end
  endtask

  task automatic wait_rises(input int target);
    for (int n = 0; n < 300; n++) begin
      if (rises >= target) break;
      @(posedge sys_clk);
      #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, seed2;

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cyc",  {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("rst_stb",  {31'd0, wb.wbm_stb_o}, 32'd0);
    chk("rst_we",   {31'd0, wb.wbm_we_o},  32'd0);
    chk("rst_sel",  {28'd0, wb.wbm_sel_o}, 32'd0);
    chk("rst_adr",  wb.wbm_adr_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    csr_rd(A_BASE, d);     chk("rst_base", d, 32'd0);
    csr_rd(A_COUNT, d);    chk("rst_count", d, 32'd0);
    csr_rd(A_SEED, d);     chk("rst_seed", d, 32'd1);
    csr_rd(A_STAT, d);     chk("rst_stat", d, 32'd0);
    csr_rd(A_ERRCNT, d);   chk("rst_errcnt", d, 32'd0);
    csr_rd(A_FIRSTERR, d); chk("rst_firsterr", d, 32'd0);

    // 1: zero-wait slave, 3 words at 0x100, seed 1
    sl_base = 32'h100;
    csr_wr(A_BASE, 32'h103);
    csr_rd(A_BASE, d); chk("base_align", d, 32'h100);
    csr_a = {4'h2, 7'd0, A_BASE};
    @(posedge sys_clk);
    #1 chk("page_miss", csr_do, 32'd0);
    csr_wr(A_COUNT, 32'd3);
    csr_wr(A_SEED, 32'd1);
    sb.push_back(acc_t'{we: 1'b1, adr: 32'h100, dat: 32'h0000_0001});
    sb.push_back(acc_t'{we: 1'b1, adr: 32'h104, dat: 32'h8020_0003});
    sb.push_back(acc_t'{we: 1'b1, adr: 32'h108, dat: 32'hC030_0002});
    sb.push_back(acc_t'{we: 1'b0, adr: 32'h100, dat: 32'h0000_0001});
    sb.push_back(acc_t'{we: 1'b0, adr: 32'h104, dat: 32'h8020_0003});
    sb.push_back(acc_t'{we: 1'b0, adr: 32'h108, dat: 32'hC030_0002});
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    wait_done(d);      chk("t1_stat", d, 32'h2);
    csr_rd(A_ERRCNT, d); chk("t1_errcnt", d, 32'd0);
    chk("t1_sb_empty", sb.size(), 32'd0);
    chk("t1_accesses", rises, 32'd6);
    chk("t1_stb_len", last_run, 32'd1);

    // 2: read words 1 and 2 corrupted
    corrupt = 64'h6;
    push_run(32'h100, 3, 32'd1, 1'b1);
    csr_wr(A_CTRL, 32'd1);
    wait_done(d);          chk("t2_stat", d, 32'h6);
    csr_rd(A_ERRCNT, d);   chk("t2_errcnt", d, 32'd2);
    csr_rd(A_FIRSTERR, d); chk("t2_firsterr", d, 32'h104);
    corrupt = '0;

    // 3: slave never acks
    never_ack = 1'b1;
    csr_wr(A_COUNT, 32'd4);
    push_run(32'h100, 1, 32'd1, 1'b0);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    wait_done(d); chk("t3_stat", d, 32'h0A);
    chk("t3_stb_len", last_run, 32'd16);
    repeat (20) @(posedge sys_clk);
    #2 chk("t3_accesses", rises, 32'd1);
    chk("t3_sb_empty", sb.size(), 32'd0);
    never_ack = 1'b0;

    // 4: COUNT=0, then a second start during a COUNT=8 run
    csr_wr(A_COUNT, 32'd0);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    csr_rd(A_STAT, d); chk("t4_stat_busy", d, 32'h1);
    csr_rd(A_STAT, d); chk("t4_stat_done", d, 32'h2);
    chk("t4_no_cyc", rises, 32'd0);
    lat = 3;
    sl_base = 32'h2000;
    csr_wr(A_BASE, 32'h2000);
    csr_wr(A_COUNT, 32'd8);
    csr_wr(A_SEED, 32'h1234);
    push_run(32'h2000, 8, 32'h1234, 1'b1);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    repeat (12) @(posedge sys_clk);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    csr_wr(A_BASE, 32'h9000);
    csr_wr(A_SEED, 32'h5);
    csr_wr(A_CTRL, 32'd1);
    wait_done(d);        chk("t4_run_stat", d, 32'h2);
    csr_rd(A_ERRCNT, d); chk("t4_errcnt", d, 32'd0);
    chk("t4_accesses", rises, 32'd16);
    chk("t4_sb_empty", sb.size(), 32'd0);
    csr_rd(A_BASE, d);   chk("t4_base_kept", d, 32'h2000);
    csr_rd(A_SEED, d);   chk("t4_seed_kept", d, 32'h1234);

    // 5: abort during word 2 with 5-cycle latency
    lat = 5;
    sl_base = 32'h3000;
    csr_wr(A_BASE, 32'h3000);
    csr_wr(A_COUNT, 32'd6);
    csr_wr(A_SEED, 32'd7);
    push_run(32'h3000, 3, 32'd7, 1'b0);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    wait_rises(3);
    chk("t5_word2_seen", rises, 32'd3);
    csr_wr(A_CTRL, 32'd2);
    wait_done(d); chk("t5_stat", d, 32'h12);
    chk("t5_word2_len", last_run, 32'd6);
    repeat (10) @(posedge sys_clk);
    #2 chk("t5_accesses", rises, 32'd3);
    chk("t5_sb_empty", sb.size(), 32'd0);

    // reset pulsed mid-access
    csr_wr(A_BASE, 32'h4000);
    csr_wr(A_COUNT, 32'd4);
    push_run(32'h4000, 1, 32'd7, 1'b0);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    wait_rises(1);
    chk("rstm_started", rises, 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rstm_cyc",  {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("rstm_stb",  {31'd0, wb.wbm_stb_o}, 32'd0);
    chk("rstm_sel",  {28'd0, wb.wbm_sel_o}, 32'd0);
    chk("rstm_we",   {31'd0, wb.wbm_we_o},  32'd0);
    chk("rstm_adr",  wb.wbm_adr_o, 32'd0);
    chk("rstm_dat",  wb.wbm_dat_o, 32'd0);
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    sb.delete();
    csr_rd(A_BASE, d); chk("rstm_base", d, 32'd0);
    csr_rd(A_SEED, d); chk("rstm_seed", d, 32'd1);
    csr_rd(A_STAT, d); chk("rstm_stat", d, 32'd0);

    // 6: random latency, 64 words wrapping past 2^32, seed 0 then random seed
    rand_lat = 1'b1;
    sl_base = 32'hFFFF_FF80;
    csr_wr(A_BASE, 32'hFFFF_FF80);
    csr_wr(A_COUNT, 32'd64);
    csr_wr(A_SEED, 32'd0);
    csr_rd(A_SEED, d); chk("t6_seed0", d, 32'd1);
    push_run(32'hFFFF_FF80, 64, 32'd0, 1'b1);
    rises = 0;
    csr_wr(A_CTRL, 32'd1);
    wait_done(d);        chk("t6_stat", d, 32'h2);
    csr_rd(A_ERRCNT, d); chk("t6_errcnt", d, 32'd0);
    chk("t6_accesses", rises, 32'd128);
    chk("t6_sb_empty", sb.size(), 32'd0);
    seed2 = $urandom;
    csr_wr(A_SEED, seed2);
    push_run(32'hFFFF_FF80, 64, seed2, 1'b1);
    csr_wr(A_CTRL, 32'd1);
    wait_done(d);        chk("t6b_stat", d, 32'h2);
    csr_rd(A_ERRCNT, d); chk("t6b_errcnt", d, 32'd0);
    chk("t6b_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
